// File: rtl/dest_reg_pipe.sv
// Destination register select plus a STAGES-deep address/write-enable pipeline
// with stall/flush, per-stage hazard compare and nearest-stage forward index.
module dest_reg_pipe #(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 3,
    parameter int STAGES   = 3,
    parameter int LINK_REG = 31,
    parameter int SP_REG   = 29,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*ADDR_W-1:0] src,
    input  logic                      issue_valid,
    input  logic                      reg_write,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         query_rs,
    input  logic [ADDR_W-1:0]         query_rt,
    output logic [STAGES*ADDR_W-1:0]  stage_addr,
    output logic [STAGES-1:0]         stage_we,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic                      wb_we,
    output logic [STAGES-1:0]         hit_rs,
    output logic [STAGES-1:0]         hit_rt,
    output logic [3:0]                fwd_rs_idx,
    output logic [3:0]                fwd_rt_idx,
    output logic                      illegal_sel
);

    logic [STAGES-1:0][ADDR_W-1:0] addr_q;
    logic [STAGES-1:0]             we_q;
    logic [ADDR_W-1:0]             sel_addr;
    logic                          sel_legal;
    logic                          new_we;

    always_comb begin
        sel_addr  = '0;
        sel_legal = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_addr  = src[k*ADDR_W +: ADDR_W];
                sel_legal = 1'b1;
            end
        end
        if (sel == SEL_W'(NUM_SRC)) begin
            sel_addr  = ADDR_W'(LINK_REG);
            sel_legal = 1'b1;
        end
        if (sel == SEL_W'(NUM_SRC + 1)) begin
            sel_addr  = ADDR_W'(SP_REG);
            sel_legal = 1'b1;
        end
    end

    // Writes to $0 are architecturally void, so they never carry we downstream.
    assign new_we = issue_valid & reg_write & sel_legal & (sel_addr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            we_q        <= '0;
            illegal_sel <= 1'b0;
        end else begin
            if (flush) begin
                addr_q[0] <= '0;
                we_q[0]   <= 1'b0;
            end else if (!stall) begin
                addr_q[0] <= issue_valid ? sel_addr : '0;
                we_q[0]   <= new_we;
            end
            if (!stall) begin
                for (int s = 1; s < STAGES; s++) begin
                    addr_q[s] <= addr_q[s-1];
                    we_q[s]   <= we_q[s-1];
                end
            end
            if (issue_valid && !stall && !sel_legal)
                illegal_sel <= 1'b1;
        end
    end

    always_comb begin
        stage_addr = '0;
        for (int s = 0; s < STAGES; s++)
            stage_addr[s*ADDR_W +: ADDR_W] = addr_q[s];
    end

    assign stage_we = we_q;
    assign wb_addr  = addr_q[STAGES-1];
    assign wb_we    = we_q[STAGES-1];

    // Scan oldest to youngest so the youngest (lowest) matching stage wins.
    always_comb begin
        hit_rs     = '0;
        hit_rt     = '0;
        fwd_rs_idx = '0;
        fwd_rt_idx = '0;
        for (int s = 0; s < STAGES; s++) begin
            hit_rs[s] = we_q[s] && (addr_q[s] == query_rs) && (query_rs != '0);
            hit_rt[s] = we_q[s] && (addr_q[s] == query_rt) && (query_rt != '0);
        end
        for (int s = STAGES - 1; s >= 0; s--) begin
            if (hit_rs[s]) fwd_rs_idx = 4'(s + 1);
            if (hit_rt[s]) fwd_rt_idx = 4'(s + 1);
        end
    end

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed bench for dest_reg_pipe with default parameters (3 sources, 3 stages).
module tb_dest_reg_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  sel;
    logic [14:0] src;
    logic        issue_valid, reg_write, stall, flush;
    logic [4:0]  query_rs, query_rt;
    logic [14:0] stage_addr;
    logic [2:0]  stage_we;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic [2:0]  hit_rs, hit_rt;
    logic [3:0]  fwd_rs_idx, fwd_rt_idx;
    logic        illegal_sel;

    int checks = 0;
    int failures = 0;

    dest_reg_pipe dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .src(src),
        .issue_valid(issue_valid), .reg_write(reg_write),
        .stall(stall), .flush(flush),
        .query_rs(query_rs), .query_rt(query_rt),
        .stage_addr(stage_addr), .stage_we(stage_we),
        .wb_addr(wb_addr), .wb_we(wb_we),
        .hit_rs(hit_rs), .hit_rt(hit_rt),
        .fwd_rs_idx(fwd_rs_idx), .fwd_rt_idx(fwd_rt_idx),
        .illegal_sel(illegal_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [4:0] s2,
                         input logic [4:0] s1, input logic [4:0] s0, input logic rw);
        issue_valid = v;
        sel         = s;
        src         = {s2, s1, s0};
        reg_write   = rw;
    endtask

    initial begin
        reset_n = 1'b0;
        stall = 1'b0; flush = 1'b0;
        query_rs = '0; query_rt = '0;
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(); tick();
        check("rst_addr", 32'(stage_addr), 32'h0);
        check("rst_we", 32'(stage_we), 32'h0);
        check("rst_illegal", 32'(illegal_sel), 32'h0);
        reset_n = 1'b1;

        // sel=1 -> src1=8, then link and stack constants
        drive(1'b1, 3'd1, 5'd0, 5'd8, 5'd0, 1'b1);
        tick();
        check("s1_addr_src1", 32'(stage_addr[4:0]), 32'd8);
        check("s1_we_src1", 32'(stage_we[0]), 32'd1);
        drive(1'b1, 3'd3, 5'd0, 5'd8, 5'd0, 1'b1);
        tick();
        check("s1_addr_link", 32'(stage_addr[4:0]), 32'd31);
        check("s2_addr_src1", 32'(stage_addr[9:5]), 32'd8);
        drive(1'b1, 3'd4, 5'd0, 5'd8, 5'd0, 1'b1);
        tick();
        check("s1_addr_sp", 32'(stage_addr[4:0]), 32'd29);
        check("wb_addr", 32'(wb_addr), 32'd8);
        check("wb_we", 32'(wb_we), 32'd1);
        check("we_all", 32'(stage_we), 32'b111);

        // bubble, then write to $0 (suppressed)
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        check("zero_addr", 32'(stage_addr), {17'd0, 5'd29, 5'd0, 5'd0});
        check("zero_we", 32'(stage_we), 32'b100);
        query_rs = 5'd0; #1;
        check("zero_hit", 32'(hit_rs), 32'b000);
        check("zero_fwd", 32'(fwd_rs_idx), 32'd0);
        query_rs = 5'd29; #1;
        check("hit29", 32'(hit_rs), 32'b100);
        check("fwd29", 32'(fwd_rs_idx), 32'd3);

        // back-to-back writes to $5
        drive(1'b1, 3'd0, 5'd0, 5'd0, 5'd5, 1'b1);
        tick(); tick();
        query_rs = 5'd5; query_rt = 5'd5; #1;
        check("b2b_hit_rs", 32'(hit_rs), 32'b011);
        check("b2b_fwd_rs", 32'(fwd_rs_idx), 32'd1);
        check("b2b_hit_rt", 32'(hit_rt), 32'b011);
        check("b2b_fwd_rt", 32'(fwd_rt_idx), 32'd1);
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("b2b_hit_late", 32'(hit_rs), 32'b110);
        check("b2b_fwd_late", 32'(fwd_rs_idx), 32'd2);
        query_rt = 5'd4; #1;
        check("rt_miss", 32'(fwd_rt_idx), 32'd0);

        // $9 into stage 2, then stall for 2 cycles with an issue present
        drive(1'b1, 3'd0, 5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("pre_stall_addr", 32'(stage_addr), {17'd0, 5'd0, 5'd9, 5'd0});
        stall = 1'b1;
        drive(1'b1, 3'd0, 5'd0, 5'd0, 5'd7, 1'b1);
        tick(); tick();
        check("stall_addr", 32'(stage_addr), {17'd0, 5'd0, 5'd9, 5'd0});
        check("stall_we", 32'(stage_we), 32'b010);
        stall = 1'b0;
        tick();
        check("unstall_addr", 32'(stage_addr), {17'd0, 5'd9, 5'd0, 5'd7});
        stall = 1'b1; flush = 1'b1;
        tick();
        check("stflush_addr", 32'(stage_addr), {17'd0, 5'd9, 5'd0, 5'd0});
        check("stflush_we", 32'(stage_we), 32'b100);
        stall = 1'b0;
        tick();
        check("flush_adv_addr", 32'(stage_addr), {17'd0, 5'd0, 5'd0, 5'd0});
        flush = 1'b0;

        // illegal select is sticky
        check("pre_illegal", 32'(illegal_sel), 32'd0);
        drive(1'b1, 3'd6, 5'd3, 5'd3, 5'd3, 1'b1);
        tick();
        check("illegal_set", 32'(illegal_sel), 32'd1);
        check("illegal_we", 32'(stage_we[0]), 32'd0);
        check("illegal_addr", 32'(stage_addr[4:0]), 32'd0);
        drive(1'b1, 3'd2, 5'd12, 5'd3, 5'd3, 1'b1);
        tick();
        check("illegal_sticky", 32'(illegal_sel), 32'd1);
        check("s1_addr_src2", 32'(stage_addr[4:0]), 32'd12);
        query_rs = 5'd12; #1;
        check("hit12", 32'(hit_rs), 32'b001);

        // async reset mid-cycle, no clock edge before checking
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_addr", 32'(stage_addr), 32'h0);
        check("arst_we", 32'(stage_we), 32'h0);
        check("arst_illegal", 32'(illegal_sel), 32'd0);
        check("arst_hit", 32'(hit_rs), 32'b000);
        check("arst_fwd", 32'(fwd_rs_idx), 32'd0);
        check("arst_wb_we", 32'(wb_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dest_reg_pipe.md
Name: dest_reg_pipe

Overview:
- Parametrised successor of the write-register destination multiplexer.
- Selects the destination register address from N instruction fields plus fixed link/stack constants.
- Carries the selected address and write-enable through STAGES pipeline registers (EX/MEM/WB), with stall and flush.
- Exposes per-stage match flags and a nearest-stage index for the hazard/forwarding unit. Sits between the decoder/control unit and the register file write port.

Parameters:
- ADDR_W, 5, register address width.
- NUM_SRC, 3, number of instruction-field address sources; sel values 0..NUM_SRC-1 choose src[k].
- STAGES, 3, number of pipeline stages after selection (2..8).
- LINK_REG, 31, constant chosen by sel == NUM_SRC.
- SP_REG, 29, constant chosen by sel == NUM_SRC+1.
- SEL_W, 3, select width; must satisfy 2^SEL_W >= NUM_SRC+2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sel  in  SEL_W  destination source select.
- src  in  NUM_SRC*ADDR_W  packed address fields; src[k] = bits [k*ADDR_W +: ADDR_W].
- issue_valid  in  1  instruction entering stage 1 this cycle.
- reg_write  in  1  instruction writes a register.
- stall  in  1  freeze all stages.
- flush  in  1  kill the instruction in stage 1.
- query_rs  in  ADDR_W  source-operand address A to compare.
- query_rt  in  ADDR_W  source-operand address B to compare.
- stage_addr  out  STAGES*ADDR_W  registered destination address per stage.
- stage_we  out  STAGES  registered effective write-enable per stage.
- wb_addr  out  ADDR_W  alias of the last stage address.
- wb_we  out  1  alias of the last stage write-enable.
- hit_rs  out  STAGES  per-stage match for query_rs.
- hit_rt  out  STAGES  per-stage match for query_rt.
- fwd_rs_idx  out  4  nearest matching stage (1..STAGES) for rs; 0 = none.
- fwd_rt_idx  out  4  nearest matching stage (1..STAGES) for rt; 0 = none.
- illegal_sel  out  1  sticky error flag.

Behaviour:
- Select (combinational, fully specified, no latches):
  - sel < NUM_SRC -> src[sel]
  - sel == NUM_SRC -> LINK_REG
  - sel == NUM_SRC+1 -> SP_REG
  - any other value -> address 0 with write suppressed.
- Effective we = issue_valid & reg_write & legal sel & (selected addr != 0). Writes to $0 never propagate as we = 1.
- Reset (async, reset_n low): all stage_addr = 0, stage_we = 0, illegal_sel = 0. Consequently hit_* = 0, fwd_*_idx = 0, wb_we = 0. Release takes effect at the next rising clk.
- Latency: a selection issued at edge t appears in stage 1 after t, and in stage s after edge t+s-1. wb_addr/wb_we are valid STAGES cycles after issue.
- Stall = 1, flush = 0: every stage holds its value; issue is ignored (the upstream unit re-presents the instruction).
- Flush = 1: stage 1 loads addr 0, we 0 regardless of stall or issue_valid.
  - If stall = 0, the stages beyond stage 1 advance normally.
  - If stall = 1, the stages beyond stage 1 hold.
- Normal (stall = 0, flush = 0): stage s+1 <= stage s; stage 1 <= new selection, or a bubble (0/0) when issue_valid = 0.
- Hazard compare (combinational on registered state):
  - hit_rs[s] = stage_we[s] & (stage_addr[s] == query_rs) & (query_rs != 0); hit_rt is identical using query_rt.
  - fwd_*_idx = lowest s with hit, because stage 1 is the youngest instruction and wins.
- illegal_sel is set on a clock edge when issue_valid = 1, stall = 0 and sel is illegal. It stays set until reset.
- No internal counters overflow; stages have no wrap-around.

Test Plan:
- Reset with stages loaded, reset_n low mid-cycle -> all outputs 0 immediately, without waiting for clk.
- NUM_SRC = 3, STAGES = 3; issue sel = 1, src1 = 8, reg_write = 1 -> stage_addr[1] = 8 after 1 edge; wb_addr = 8 and wb_we = 1 after 3 edges; sel = 3 -> 31; sel = 4 -> 29.
- Issue sel = 0, src0 = 0, reg_write = 1 -> stages carry addr 0, we 0; query_rs = 0 -> no hit, fwd_rs_idx = 0.
- Back-to-back writes to $5 issued then $5 again; query_rs = 5 -> hit_rs = 3'b011, fwd_rs_idx = 1.
- Stall for 2 cycles with $9 in stage 2 -> it stays in stage 2; stall + flush -> stage 1 = 0/0 while stages 2–3 hold.
- sel = 6 with issue_valid = 1 -> illegal_sel rises next edge; stage 1 we = 0; flag remains 1 through later legal issues until reset_n = 0.
